// File: rtl/ocs_slot_scheduler.sv
// rtl/ocs_slot_scheduler.sv - round-robin time-slot scheduler for the 8x8 optical circuit switch
// Optional feature macro: OCS_EPOCH_CNT_EN adds the o_epoch_cnt completed-round counter.
module ocs_slot_scheduler #(
  parameter int P_SLOT_NUM  = 4,
  parameter int P_GUARD_CYC = 8,
  parameter int P_LEN_W     = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_cfg_wr,
  input  logic [1:0]         i_cfg_addr,
  input  logic [19:0]        i_cfg_grant,
  input  logic [1:0]         i_slot_last,
  input  logic [P_LEN_W-1:0] i_slot_len,
  input  logic               i_start,
  input  logic               i_stop,
  output logic [19:0]        o_grant,
  output logic               o_data_valid,
  output logic [1:0]         o_slot_idx,
  output logic               o_busy
`ifdef OCS_EPOCH_CNT_EN
  ,
  output logic [15:0]        o_epoch_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_GUARD,
    S_ACTIVE
  } state_t;

  localparam logic [7:0]         GUARD_INIT = 8'(P_GUARD_CYC - 1);
  localparam logic [P_LEN_W-1:0] LEN_ONE    = {{(P_LEN_W-1){1'b0}}, 1'b1};

  state_t             state;
  state_t             state_nxt;
  logic               start_q;
  logic               stop_pend;
  logic [1:0]         idx;
  logic [1:0]         last_q;
  logic [7:0]         guard_cnt;
  logic [P_LEN_W-1:0] len_cnt;
  logic [19:0]        tbl [P_SLOT_NUM];
  logic               slot_done;
  logic               wrap;

  // The last entry of the sampled range wraps the index back to 0.
  assign wrap = (idx == last_q);

  // Grant table: host writes land at the edge; a LOAD at the same edge sees the old word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < P_SLOT_NUM; i++) begin
        tbl[i] <= '0;
      end
    end else if (i_cfg_wr) begin
      tbl[i_cfg_addr] <= i_cfg_grant;
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: a slot always runs to the end of its active window before stopping.
  always_comb begin
    state_nxt = state;
    slot_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_q) begin
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        state_nxt = S_GUARD;
      end
      S_GUARD: begin
        if (guard_cnt == 8'd0) begin
          state_nxt = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (len_cnt == '0) begin
          slot_done = 1'b1;
          state_nxt = stop_pend ? S_IDLE : S_LOAD;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: counters, slot index, stop request and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      start_q      <= 1'b0;
      stop_pend    <= 1'b0;
      idx          <= 2'd0;
      last_q       <= 2'd0;
      guard_cnt    <= 8'd0;
      len_cnt      <= '0;
      o_grant      <= 20'h0;
      o_data_valid <= 1'b0;
      o_slot_idx   <= 2'd0;
      o_busy       <= 1'b0;
`ifdef OCS_EPOCH_CNT_EN
      o_epoch_cnt  <= 16'h0;
`endif
    end else begin
      // Start is only honoured from IDLE; a start/stop pair in IDLE drops the stop.
      start_q <= i_start && (state == S_IDLE) && !start_q;
      if (i_stop && (state != S_IDLE)) begin
        stop_pend <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (start_q) begin
            idx       <= 2'd0;
            stop_pend <= 1'b0;
`ifdef OCS_EPOCH_CNT_EN
            o_epoch_cnt <= 16'h0;
`endif
          end
        end
        S_LOAD: begin
          o_grant    <= tbl[idx];
          o_slot_idx <= idx;
          last_q     <= i_slot_last;
          guard_cnt  <= GUARD_INIT;
          len_cnt    <= (i_slot_len == '0) ? '0 : i_slot_len - LEN_ONE;
        end
        S_GUARD: begin
          if (guard_cnt != 8'd0) begin
            guard_cnt <= guard_cnt - 8'd1;
          end
        end
        S_ACTIVE: begin
          if (!slot_done) begin
            len_cnt <= len_cnt - LEN_ONE;
          end else begin
`ifdef OCS_EPOCH_CNT_EN
            if (wrap) begin
              o_epoch_cnt <= o_epoch_cnt + 16'd1;
            end
`endif
            if (!stop_pend) begin
              idx <= wrap ? 2'd0 : idx + 2'd1;
            end
          end
        end
        default: begin
        end
      endcase

      // Fabric returns to all-bar as soon as the run ends.
      if ((state_nxt == S_IDLE) && (state != S_IDLE)) begin
        o_grant <= 20'h0;
      end
      o_data_valid <= (state_nxt == S_ACTIVE);
      o_busy       <= (state_nxt != S_IDLE);
    end
  end

endmodule

// File: tb/tb_ocs_slot_scheduler.sv
// tb/tb_ocs_slot_scheduler.sv - scoreboard bench for ocs_slot_scheduler
module tb_ocs_slot_scheduler;

  localparam int G = 8;

  typedef struct {
    logic [19:0] grant;
    logic [1:0]  idx;
    int          start;
    int          len;
    bit          stable;
  } slot_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_wr;
  logic [1:0]  cfg_addr;
  logic [19:0] cfg_grant;
  logic [1:0]  slot_last;
  logic [15:0] slot_len;
  logic        start;
  logic        stop;
  logic [19:0] grant;
  logic        data_valid;
  logic [1:0]  slot_idx;
  logic        busy;
`ifdef OCS_EPOCH_CNT_EN
  logic [15:0] epoch_cnt;
`endif

  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  slot_t exp_q[$];
  slot_t obs_q[$];
  slot_t cur;
  bit    in_slot = 1'b0;

  ocs_slot_scheduler #(.P_SLOT_NUM(4), .P_GUARD_CYC(G), .P_LEN_W(16)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_cfg_wr     (cfg_wr),
    .i_cfg_addr   (cfg_addr),
    .i_cfg_grant  (cfg_grant),
    .i_slot_last  (slot_last),
    .i_slot_len   (slot_len),
    .i_start      (start),
    .i_stop       (stop),
    .o_grant      (grant),
    .o_data_valid (data_valid),
    .o_slot_idx   (slot_idx),
    .o_busy       (busy)
`ifdef OCS_EPOCH_CNT_EN
    ,
    .o_epoch_cnt  (epoch_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Slot monitor: one record per open window, with start cycle, length and grant stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      in_slot = 1'b0;
    end else begin
      if (data_valid && !in_slot) begin
        in_slot    = 1'b1;
        cur.grant  = grant;
        cur.idx    = slot_idx;
        cur.start  = cyc;
        cur.len    = 0;
        cur.stable = 1'b1;
      end
      if (data_valid) begin
        cur.len = cur.len + 1;
        if (grant !== cur.grant) cur.stable = 1'b0;
      end
      if (!data_valid && in_slot) begin
        in_slot = 1'b0;
        obs_q.push_back(cur);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic write_entry(input logic [1:0] a, input logic [19:0] g);
    cfg_wr    = 1'b1;
    cfg_addr  = a;
    cfg_grant = g;
    tick(1);
    cfg_wr    = 1'b0;
  endtask

  task automatic load_ramp();
    write_entry(2'd0, 20'h00001);
    write_entry(2'd1, 20'h00002);
    write_entry(2'd2, 20'h00004);
    write_entry(2'd3, 20'h00008);
  endtask

  task automatic pulse_start(output int s);
    start = 1'b1;
    s = cyc + 1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic push_exp(input logic [19:0] g, input logic [1:0] i, input int st, input int l);
    slot_t e;
    e.grant  = g;
    e.idx    = i;
    e.start  = st;
    e.len    = l;
    e.stable = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    int bad;
    rst_n = 1'b0;
    #1;
    checks++;
    if (grant !== 20'h0 || data_valid !== 1'b0 || busy !== 1'b0 || slot_idx !== 2'd0) begin
      errors++;
      $display("FAIL reset_values got grant=%h dv=%b busy=%b idx=%0d want 0 0 0 0", grant, data_valid, busy, slot_idx);
    end
    tick(2);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (grant !== 20'h0 || data_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_quiet got %0d bad cycles want 0", bad);
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL idle_no_slot got %0d slots want 0", obs_q.size());
    end
    tick(1);
  endtask

  task automatic test_rotation();
    int s;
    slot_t e, o;
    load_ramp();
    slot_last = 2'd3;
    slot_len  = 16'd5;
    pulse_start(s);
    for (int k = 0; k < 8; k++) push_exp(20'h1 << (k % 4), 2'(k % 4), s + G + 2 + k * (1 + G + 5), 5);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rot_busy_edge0 got %b want 0", busy); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || grant !== 20'h0) begin
      errors++;
      $display("FAIL rot_load_edge got busy=%b grant=%h want busy=1 grant=00000", busy, grant);
    end
    @(negedge clk);
    checks++;
    if (grant !== 20'h00001) begin errors++; $display("FAIL rot_first_grant got %h want 00001", grant); end
    for (int i = 0; i < 400 && obs_q.size() < 8; i++) @(negedge clk);
    checks++;
    if (obs_q.size() < 8) begin errors++; $display("FAIL rot_timeout got %0d slots want 8", obs_q.size()); end
`ifdef OCS_EPOCH_CNT_EN
    checks++;
    if (epoch_cnt !== 16'd2) begin errors++; $display("FAIL rot_epoch got %0d want 2", epoch_cnt); end
`endif
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.grant !== e.grant || o.idx !== e.idx || o.start != e.start || o.len != e.len || !o.stable) begin
        errors++;
        $display("FAIL rot_slot got grant=%h idx=%0d start=%0d len=%0d stable=%0b want grant=%h idx=%0d start=%0d len=%0d",
                 o.grant, o.idx, o.start, o.len, o.stable, e.grant, e.idx, e.start, e.len);
      end
    end
    do_reset();
  endtask

  task automatic test_stop();
    int s;
    slot_t e, o;
    load_ramp();
    slot_last = 2'd1;
    slot_len  = 16'd5;
    pulse_start(s);
    push_exp(20'h00001, 2'd0, s + G + 2, 5);
    push_exp(20'h00002, 2'd1, s + 2 * G + 8, 5);
    while (cyc < s + 2 * G + 10) tick(1);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    for (int i = 0; i < 200 && obs_q.size() < 2; i++) @(negedge clk);
    checks++;
    if (obs_q.size() < 2) begin errors++; $display("FAIL stop_timeout got %0d slots want 2", obs_q.size()); end
    checks++;
    if (grant !== 20'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stop_end got grant=%h busy=%b want grant=00000 busy=0", grant, busy);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.grant !== e.grant || o.idx !== e.idx || o.start != e.start || o.len != e.len || !o.stable) begin
        errors++;
        $display("FAIL stop_slot got grant=%h idx=%0d start=%0d len=%0d stable=%0b want grant=%h idx=%0d start=%0d len=%0d",
                 o.grant, o.idx, o.start, o.len, o.stable, e.grant, e.idx, e.start, e.len);
      end
    end
    tick(30);
    checks++;
    if (obs_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stop_stays_idle got slots=%0d busy=%b want 0 0", obs_q.size(), busy);
    end
    // Restart with start and stop together: the stop is dropped and the run begins at idx 0.
    start = 1'b1;
    stop  = 1'b1;
    s = cyc + 1;
    tick(1);
    start = 1'b0;
    stop  = 1'b0;
    push_exp(20'h00001, 2'd0, s + G + 2, 5);
    push_exp(20'h00002, 2'd1, s + 2 * G + 8, 5);
    for (int i = 0; i < 200 && obs_q.size() < 2; i++) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL restart_busy got %b want 1", busy); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.grant !== e.grant || o.idx !== e.idx || o.start != e.start || o.len != e.len || !o.stable) begin
        errors++;
        $display("FAIL restart_slot got grant=%h idx=%0d start=%0d len=%0d stable=%0b want grant=%h idx=%0d start=%0d len=%0d",
                 o.grant, o.idx, o.start, o.len, o.stable, e.grant, e.idx, e.start, e.len);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL restart_timeout got %0d missing slots want 0", exp_q.size()); end
    do_reset();
  endtask

  task automatic test_len_zero();
    int s;
    slot_t e, o;
    write_entry(2'd0, 20'h00010);
    slot_last = 2'd0;
    slot_len  = 16'd0;
    pulse_start(s);
    for (int k = 0; k < 4; k++) push_exp(20'h00010, 2'd0, s + G + 2 + k * (G + 2), 1);
    for (int i = 0; i < 200 && obs_q.size() < 4; i++) @(negedge clk);
    checks++;
    if (obs_q.size() < 4) begin errors++; $display("FAIL len0_timeout got %0d slots want 4", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.grant !== e.grant || o.idx !== e.idx || o.start != e.start || o.len != e.len || !o.stable) begin
        errors++;
        $display("FAIL len0_slot got grant=%h idx=%0d start=%0d len=%0d stable=%0b want grant=%h idx=%0d start=%0d len=%0d",
                 o.grant, o.idx, o.start, o.len, o.stable, e.grant, e.idx, e.start, e.len);
      end
    end
    do_reset();
  endtask

  task automatic test_write_collision();
    int s;
    slot_t e, o;
    load_ramp();
    slot_last = 2'd3;
    slot_len  = 16'd5;
    pulse_start(s);
    for (int k = 0; k < 6; k++)
      push_exp((k == 5) ? 20'hFFFFF : (20'h1 << (k % 4)), 2'(k % 4), s + G + 2 + k * (G + 6), 5);
    // Entry 1 is rewritten on the very edge that loads it for slot 1.
    while (cyc < s + G + 7) tick(1);
    cfg_wr    = 1'b1;
    cfg_addr  = 2'd1;
    cfg_grant = 20'hFFFFF;
    tick(1);
    cfg_wr    = 1'b0;
    for (int i = 0; i < 300 && obs_q.size() < 6; i++) @(negedge clk);
    checks++;
    if (obs_q.size() < 6) begin errors++; $display("FAIL coll_timeout got %0d slots want 6", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.grant !== e.grant || o.idx !== e.idx || o.start != e.start || o.len != e.len || !o.stable) begin
        errors++;
        $display("FAIL coll_slot got grant=%h idx=%0d start=%0d len=%0d stable=%0b want grant=%h idx=%0d start=%0d len=%0d",
                 o.grant, o.idx, o.start, o.len, o.stable, e.grant, e.idx, e.start, e.len);
      end
    end
    do_reset();
  endtask

  task automatic test_reset_mid_guard();
    int s;
    slot_t e, o;
    load_ramp();
    slot_last = 2'd3;
    slot_len  = 16'd5;
    pulse_start(s);
    while (cyc < s + G + 10) tick(1);
    checks++;
    if (grant !== 20'h00002 || slot_idx !== 2'd1 || data_valid !== 1'b0) begin
      errors++;
      $display("FAIL guard_state got grant=%h idx=%0d dv=%b want 00002 1 0", grant, slot_idx, data_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (grant !== 20'h0 || data_valid !== 1'b0 || busy !== 1'b0 || slot_idx !== 2'd0) begin
      errors++;
      $display("FAIL guard_reset got grant=%h dv=%b busy=%b idx=%0d want 0 0 0 0", grant, data_valid, busy, slot_idx);
    end
    tick(2);
    rst_n = 1'b1;
    tick(1);
    obs_q.delete();
    exp_q.delete();
    // The table was cleared, so a fresh run drives an all-bar grant.
    slot_last = 2'd0;
    slot_len  = 16'd1;
    pulse_start(s);
    push_exp(20'h0, 2'd0, s + G + 2, 1);
    for (int i = 0; i < 100 && obs_q.size() < 1; i++) @(negedge clk);
    checks++;
    if (obs_q.size() < 1) begin errors++; $display("FAIL clr_timeout got %0d slots want 1", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.grant !== e.grant || o.idx !== e.idx || o.start != e.start || o.len != e.len || !o.stable) begin
        errors++;
        $display("FAIL clr_slot got grant=%h idx=%0d start=%0d len=%0d stable=%0b want grant=%h idx=%0d start=%0d len=%0d",
                 o.grant, o.idx, o.start, o.len, o.stable, e.grant, e.idx, e.start, e.len);
      end
    end
    do_reset();
  endtask

  initial begin
    rst_n     = 1'b0;
    cfg_wr    = 1'b0;
    cfg_addr  = 2'd0;
    cfg_grant = 20'h0;
    slot_last = 2'd0;
    slot_len  = 16'd0;
    start     = 1'b0;
    stop      = 1'b0;
    tick(3);
    test_reset();
    test_rotation();
    test_stop();
    test_len_zero();
    test_write_collision();
    test_reset_mid_guard();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
